keypad_scanner: RTL

Sequential front end for the 4x4 matrix keypad. Drives the columns one at a time, synchronises and debounces the row lines, and emits a 4-bit row/column code with a one-cycle valid strobe. The code feeds the KeyPadDecoder input directly: row 0 / column 0 (key "1") is code 4'b0000, and row 3 / column 3 (key "D") is 4'b1111.

---
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with debounce
//
// Purpose: drives keypad columns one at a time, synchronises and debounces
// the row lines and reports one {row, column} code per press/release cycle.
//
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous active-high reset
//   Row      in   [3:0] keypad rows, active-low, asynchronous to Clock
//   Col      out  [3:0] column drive, active-low one-hot
//   KeyCode  out  [3:0] {row index, column index} of the last accepted key
//   KeyValid out  one-clock pulse when a new key is accepted
//   KeyDown  out  high from acceptance until release is debounced
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyDown
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] PRESS_LAST = SW'(DEBOUNCE - 1);
  // The HELD cycle that first sees all rows high is the first stable clock of
  // a release, so RELEASE needs one fewer count than DEBOUNCE.
  localparam logic [SW-1:0] REL_LAST   = SW'(DEBOUNCE - 2);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

  state_t        state, state_n;
  logic [3:0]    row_meta, row_s;
  logic [DW-1:0] dwell, dwell_n;
  logic [SW-1:0] stab, stab_n;
  logic [1:0]    col_idx, col_n;
  logic [3:0]    cap_row, cap_n;
  logic [3:0]    code_n;
  logic          valid_n, down_n;

  function automatic logic single_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign Col = ~(4'b0001 << col_idx);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
      state    <= ST_SCAN;
      dwell    <= '0;
      stab     <= '0;
      col_idx  <= 2'd0;
      cap_row  <= 4'hF;
      KeyCode  <= 4'b0000;
      KeyValid <= 1'b0;
      KeyDown  <= 1'b0;
    end else begin
      row_meta <= Row;
      row_s    <= row_meta;
      state    <= state_n;
      dwell    <= dwell_n;
      stab     <= stab_n;
      col_idx  <= col_n;
      cap_row  <= cap_n;
      KeyCode  <= code_n;
      KeyValid <= valid_n;
      KeyDown  <= down_n;
    end
  end

  always_comb begin
    state_n = state;
    dwell_n = dwell;
    stab_n  = stab;
    col_n   = col_idx;
    cap_n   = cap_row;
    code_n  = KeyCode;
    valid_n = 1'b0;
    down_n  = KeyDown;
    case (state)
      ST_SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          if (single_low(row_s)) begin
            // Column stays put so the debounce watches the same key.
            cap_n   = row_s;
            stab_n  = '0;
            state_n = ST_DEBOUNCE;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (row_s == cap_row) begin
          if (stab == PRESS_LAST) begin
            state_n = ST_HELD;
            code_n  = {low_index(cap_row), col_idx};
            valid_n = 1'b1;
            down_n  = 1'b1;
          end else begin
            stab_n = stab + 1'b1;
          end
        end else begin
          col_n   = col_idx + 2'd1;
          dwell_n = '0;
          stab_n  = '0;
          state_n = ST_SCAN;
        end
      end
      ST_HELD: begin
        // Extra keys in this column only change row_s; only all-high matters.
        if (row_s == 4'hF) begin
          stab_n  = '0;
          state_n = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (row_s == 4'hF) begin
          if (stab == REL_LAST) begin
            down_n  = 1'b0;
            col_n   = col_idx + 2'd1;
            dwell_n = '0;
            stab_n  = '0;
            state_n = ST_SCAN;
          end else begin
            stab_n = stab + 1'b1;
          end
        end else begin
          state_n = ST_HELD;
        end
      end
      default: state_n = ST_SCAN;
    endcase
  end

endmodule
